hack_mem_arbiter: RTL and testbench
===================================

HACK_MEM_ARBITER -- requirements
Module: hack_mem_arbiter

Interface
REQ-001 Parameter VID_BASE, default 15'h4000: word address of screen memory; video offsets are added to it.
REQ-002 Parameter MAX_WAIT, default 4: maximum number of CPU grants a pending video request may lose before video wins.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port cpu_req, input, 1: CPU data-port access request.
REQ-006 Port cpu_we, input, 1: CPU request is a write (writeM).
REQ-007 Port cpu_addr, input, 15: CPU word address (addressM[14:0]).
REQ-008 Port cpu_wdata, input, 16: CPU write data (outM).
REQ-009 Port cpu_rdata, output, 16: CPU read data (inM); valid only while cpu_ack=1.
REQ-010 Port cpu_ack, output, 1: one-cycle pulse marking CPU access completion.
REQ-011 Port cpu_stall, output, 1: equals cpu_req & ~cpu_ack; freezes the CPU clock enable.
REQ-012 Port vid_req, input, 1: video scan-out read request.
REQ-013 Port vid_addr, input, 13: screen word offset, 0..8191.
REQ-014 Port vid_rdata, output, 16: video read data; valid only while vid_ack=1.
REQ-015 Port vid_ack, output, 1: one-cycle pulse marking video read completion.
REQ-016 Ports ram_en (out, 1), ram_we (out, 1), ram_addr (out, 15), ram_wdata (out, 16), ram_rdata (in, 16): single-port synchronous RAM with 1-cycle read latency.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACC (RAM command cycle), RSP (response cycle); an owner register records CPU or VID.
REQ-018 Arbitration SHALL occur in IDLE and in RSP; on grant, next state = ACC and ram_en/ram_we/ram_addr/ram_wdata are registered from the winner.
REQ-019 The winner's address/we/wdata SHALL be latched at grant; requester inputs may change after grant without affecting the access.
REQ-020 ACC SHALL always be followed by RSP; in RSP the owner's ack = 1 and owner rdata = ram_rdata (combinational pass-through); ram_en = 0.
REQ-021 Latency SHALL be exactly 2 cycles from the grant edge to ack; back-to-back grants give one access per 2 cycles.
REQ-022 A requester SHALL hold req high until ack; a req sampled high in its own RSP cycle counts as a new request.
REQ-023 Priority: CPU wins when both request, unless wait_cnt == MAX_WAIT, in which case VID wins.
REQ-024 wait_cnt (width clog2(MAX_WAIT+1)) SHALL increment, saturating at MAX_WAIT, on each CPU grant while vid_req = 1, and clear to 0 on each VID grant.
REQ-025 Video RAM address = (VID_BASE + vid_addr) mod 2^15.
REQ-026 Video access SHALL always be a read (ram_we = 0).
REQ-027 With no request in IDLE or RSP, next state = IDLE and all ram_* outputs = 0.
REQ-028 ram_we SHALL be 1 only in ACC with owner = CPU and latched we = 1.

Reset
REQ-029 While reset_n = 0: state = IDLE, owner = CPU, wait_cnt = 0; ram_en, ram_we, ram_addr, ram_wdata, cpu_ack, vid_ack, cpu_rdata, vid_rdata = 0; cpu_stall = cpu_req.
REQ-030 Reset asserted mid-access SHALL abort the access with no ack; the first grant after release is evaluated in IDLE on the first rising edge with reset_n = 1.

Structure
REQ-031 Package hack_mem_pkg SHALL hold the state enum, owner enum, SCREEN_BASE = 15'h4000, and the 15/16-bit width constants.
REQ-032 No sub-module is required; FSM, counter and muxing live in hack_mem_arbiter.

Verification
REQ-033 CPU write alone: cpu_req=1, we=1, addr=0x0010, wdata=0x3039 -> ram_we=1 with addr 0x0010 in cycle 1; cpu_ack in cycle 2; cpu_stall=1 in cycles 0-1.
REQ-034 CPU read: RAM[0x03EB]=0x1234 -> cpu_ack and cpu_rdata=0x1234 two cycles after the grant.
REQ-035 Video read with vid_addr=0x0005 -> ram_addr=0x4005 and ram_we=0; vid_ack with ram_rdata on vid_rdata.
REQ-036 Contention: cpu_req and vid_req held continuously with MAX_WAIT=4 -> grant order CPU,CPU,CPU,CPU,VID, repeating; wait_cnt returns to 0 after each VID grant.
REQ-037 Wrap: VID_BASE=15'h7FFF, vid_addr=2 -> ram_addr=0x0001.
REQ-038 Reset during ACC of a CPU write -> no cpu_ack, all outputs 0; after release, a held cpu_req is re-granted from IDLE.

Source files
------------

// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack memory arbiter.
// Contents:
//   - address, data and video-offset widths
//   - default screen base address
//   - arbiter state and owner enums
//   - the video address helper
package hack_mem_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;
    localparam int VOFF_W = 13;

    localparam logic [ADDR_W-1:0] SCREEN_BASE = 15'h4000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_VID = 1'b1
    } owner_e;

    // The screen offset is added to the base in 15-bit arithmetic, so a
    // base near the top of memory wraps around to the bottom.
    function automatic logic [ADDR_W-1:0] vid_word_addr(
        input logic [ADDR_W-1:0] base,
        input logic [VOFF_W-1:0] off
    );
        return base + {2'b00, off};
    endfunction

endpackage

// File: rtl/hack_mem_arbiter.sv
// Two-requester arbiter for one single-port synchronous RAM with a
// 1-cycle read latency. The requesters are the Hack CPU data port and the
// video scan-out.
//
// Every access takes two cycles:
//   - ACC: command cycle; the ram_* outputs drive the RAM.
//   - RSP: response cycle; the owner's ack is high and its rdata passes
//     ram_rdata straight through.
// Arbitration happens in IDLE and in RSP, so back-to-back accesses run at
// one access every two cycles.
//
// Priority:
//   - The CPU wins when both request.
//   - A waiting video request is starved out at most MAX_WAIT times.
//
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata           CPU request (held until cpu_ack)
//   cpu_rdata, cpu_ack, cpu_stall   CPU response and clock-enable freeze
//   vid_req, vid_addr               video read request, screen word offset
//   vid_rdata, vid_ack              video response
//   ram_en/we/addr/wdata, ram_rdata RAM command and read data
module hack_mem_arbiter
    import hack_mem_pkg::*;
#(
    parameter logic [ADDR_W-1:0] VID_BASE = SCREEN_BASE,
    parameter int                MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              vid_req,
    input  logic [VOFF_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    logic              vid_wins_s;
    logic              cpu_ack_s;
    logic              vid_ack_s;

    // Next-state logic: arbitration, wait counter and RAM command capture.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wait_cnt_d  = wait_cnt_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = {ADDR_W{1'b0}};
        ram_wdata_d = {DATA_W{1'b0}};

        // Video takes the slot when it is alone, or once the CPU has beaten
        // it MAX_WAIT times in a row.
        vid_wins_s  = vid_req && (!cpu_req || (wait_cnt_q == WAIT_MAX));

        case (state_q)
            ST_IDLE, ST_RSP: begin
                if (vid_wins_s) begin
                    state_d    = ST_ACC;
                    owner_d    = OWN_VID;
                    wait_cnt_d = {WCW{1'b0}};
                    ram_en_d   = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_addr_d = vid_word_addr(VID_BASE, vid_addr);
                end else if (cpu_req) begin
                    state_d     = ST_ACC;
                    owner_d     = OWN_CPU;
                    ram_en_d    = 1'b1;
                    ram_we_d    = cpu_we;
                    ram_addr_d  = cpu_addr;
                    ram_wdata_d = cpu_wdata;
                    // Count a lost round only when video was actually waiting.
                    if (vid_req && (wait_cnt_q != WAIT_MAX)) begin
                        wait_cnt_d = wait_cnt_q + WCW'(1);
                    end else begin
                        wait_cnt_d = wait_cnt_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC: begin
                // The RAM samples the command at the end of ACC.
                // Its data is back in RSP.
                state_d = ST_RSP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, owner, wait counter and registered RAM command.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_CPU;
            wait_cnt_q  <= {WCW{1'b0}};
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= {ADDR_W{1'b0}};
            ram_wdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wait_cnt_q  <= wait_cnt_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    // Response decode: the owner of the access is acknowledged in RSP.
    always_comb begin
        cpu_ack_s = 1'b0;
        vid_ack_s = 1'b0;
        if (state_q == ST_RSP) begin
            if (owner_q == OWN_CPU) begin
                cpu_ack_s = 1'b1;
            end else begin
                vid_ack_s = 1'b1;
            end
        end else begin
            cpu_ack_s = 1'b0;
            vid_ack_s = 1'b0;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

    assign cpu_ack   = cpu_ack_s;
    assign vid_ack   = vid_ack_s;
    assign cpu_rdata = cpu_ack_s ? ram_rdata : {DATA_W{1'b0}};
    assign vid_rdata = vid_ack_s ? ram_rdata : {DATA_W{1'b0}};
    assign cpu_stall = cpu_req & ~cpu_ack_s;

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Self-checking bench for hack_mem_arbiter.
//
// A transaction-level reference model predicts, for every cycle:
//   - which requester owns the RAM command slot,
//   - which requester is acknowledged,
//   - what data it must see.
// The model keeps its own shadow memory.
module tb_hack_mem_arbiter;

    localparam logic [14:0] VBASE = 15'h4000;
    localparam int          MAXW  = 4;

    logic        clk;
    logic        reset_n;
    logic        cpu_req, cpu_we;
    logic [14:0] cpu_addr;
    logic [15:0] cpu_wdata, cpu_rdata;
    logic        cpu_ack, cpu_stall;
    logic        vid_req;
    logic [12:0] vid_addr;
    logic [15:0] vid_rdata;
    logic        vid_ack;
    logic        ram_en, ram_we;
    logic [14:0] ram_addr;
    logic [15:0] ram_wdata, ram_rdata;

    // Second instance with a base at the top of memory, for the wrap case.
    logic        w_cpu_req, w_cpu_we;
    logic [14:0] w_cpu_addr;
    logic [15:0] w_cpu_wdata, w_cpu_rdata;
    logic        w_cpu_ack, w_cpu_stall;
    logic        w_vid_req;
    logic [12:0] w_vid_addr;
    logic [15:0] w_vid_rdata;
    logic        w_vid_ack;
    logic        w_ram_en, w_ram_we;
    logic [14:0] w_ram_addr;
    logic [15:0] w_ram_wdata, w_ram_rdata;

    int n_cmp = 0;
    int n_err = 0;

    hack_mem_arbiter #(.VID_BASE(VBASE), .MAX_WAIT(MAXW)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    hack_mem_arbiter #(.VID_BASE(15'h7FFF), .MAX_WAIT(MAXW)) u_wrap (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(w_cpu_req), .cpu_we(w_cpu_we), .cpu_addr(w_cpu_addr), .cpu_wdata(w_cpu_wdata),
        .cpu_rdata(w_cpu_rdata), .cpu_ack(w_cpu_ack), .cpu_stall(w_cpu_stall),
        .vid_req(w_vid_req), .vid_addr(w_vid_addr), .vid_rdata(w_vid_rdata), .vid_ack(w_vid_ack),
        .ram_en(w_ram_en), .ram_we(w_ram_we), .ram_addr(w_ram_addr), .ram_wdata(w_ram_wdata),
        .ram_rdata(w_ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power-up contents of memory; a few words are preloaded for directed reads.
    function automatic logic [15:0] mem_init(input logic [14:0] a);
        case (a)
            15'h03EB: return 16'h1234;
            15'h4005: return 16'hBEEF;
            default:  return {1'b0, a} ^ 16'h5A5A;
        endcase
    endfunction

    // Environment RAM: synchronous, read-first, 1-cycle latency.
    logic [15:0] env_mem [0:32767];
    bit          env_wr  [0:32767];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                env_mem[ram_addr] <= ram_wdata;
                env_wr[ram_addr]  <= 1'b1;
            end
            ram_rdata <= env_wr[ram_addr] ? env_mem[ram_addr] : mem_init(ram_addr);
        end
    end

    // The wrap instance sees a RAM whose data is derived from the address.
    always @(posedge clk) begin
        if (w_ram_en) w_ram_rdata <= {1'b0, w_ram_addr} + 16'h1000;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model.
    //   acc_*: the access whose command should be on the RAM port this cycle.
    //   rsp_*: the access that should be acknowledged this cycle.
    bit          acc_v, acc_vid, acc_we;
    logic [14:0] acc_addr;
    logic [15:0] acc_wd;
    bit          rsp_v, rsp_vid, rsp_rd;
    logic [15:0] rsp_data;
    int          starve = 0;
    logic [15:0] ref_mem [0:32767];
    bit          ref_wr  [0:32767];
    bit          rec_on = 1'b0;
    int          ack_q[$];

    task automatic model_step();
        bit e_cack, e_vack;
        if (!reset_n) begin
            check_eq("rst_ram_en", ram_en, 0);
            check_eq("rst_ram_we", ram_we, 0);
            check_eq("rst_ram_addr", ram_addr, 0);
            check_eq("rst_ram_wdata", ram_wdata, 0);
            check_eq("rst_cpu_ack", cpu_ack, 0);
            check_eq("rst_vid_ack", vid_ack, 0);
            check_eq("rst_cpu_rdata", cpu_rdata, 0);
            check_eq("rst_vid_rdata", vid_rdata, 0);
            check_eq("rst_cpu_stall", cpu_stall, cpu_req);
            acc_v  = 1'b0;
            rsp_v  = 1'b0;
            starve = 0;
            return;
        end

        e_cack = rsp_v && !rsp_vid;
        e_vack = rsp_v && rsp_vid;
        check_eq("cpu_ack", cpu_ack, e_cack);
        check_eq("vid_ack", vid_ack, e_vack);
        check_eq("cpu_stall", cpu_stall, cpu_req && !e_cack);
        if (e_cack && rsp_rd) check_eq("cpu_rdata", cpu_rdata, rsp_data);
        if (e_vack) check_eq("vid_rdata", vid_rdata, rsp_data);
        check_eq("ram_en", ram_en, acc_v);
        check_eq("ram_we", ram_we, acc_v && !acc_vid && acc_we);
        if (acc_v) check_eq("ram_addr", ram_addr, acc_addr);
        if (acc_v && !acc_vid && acc_we) check_eq("ram_wdata", ram_wdata, acc_wd);
        if (rec_on && (cpu_ack || vid_ack)) ack_q.push_back(vid_ack ? 1 : 0);

        // The access in its command cycle completes at the coming edge.
        if (acc_v) begin
            rsp_v    = 1'b1;
            rsp_vid  = acc_vid;
            rsp_rd   = acc_vid || !acc_we;
            rsp_data = ref_wr[acc_addr] ? ref_mem[acc_addr] : mem_init(acc_addr);
            if (!acc_vid && acc_we) begin
                ref_mem[acc_addr] = acc_wd;
                ref_wr[acc_addr]  = 1'b1;
            end
        end else begin
            rsp_v = 1'b0;
        end

        // A new access may only start when the port is not already in use.
        if (!acc_v && (cpu_req || vid_req)) begin
            if (vid_req && (!cpu_req || starve == MAXW)) begin
                acc_vid  = 1'b1;
                acc_we   = 1'b0;
                acc_addr = 15'((32'(VBASE) + 32'(vid_addr)) % 32'd32768);
                starve   = 0;
            end else begin
                acc_vid  = 1'b0;
                acc_we   = cpu_we;
                acc_addr = cpu_addr;
                acc_wd   = cpu_wdata;
                if (vid_req && starve < MAXW) starve++;
            end
            acc_v = 1'b1;
        end else begin
            acc_v = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    int p_cpu = 0;
    int p_vid = 0;

    function automatic logic [14:0] pick_cpu_addr();
        int unsigned r = $urandom_range(0, 9);
        if (r == 0)     return 15'($urandom);
        else if (r < 5) return 15'($urandom_range(0, 15));
        else            return VBASE + 15'($urandom_range(0, 15));
    endfunction

    function automatic logic [12:0] pick_vid_addr();
        if ($urandom_range(0, 7) == 0) return 13'($urandom);
        else                           return 13'($urandom_range(0, 15));
    endfunction

    // Requester agents.
    // A pending request is held until its ack. Fields are scrambled during
    // the requester's own command cycle. In the ack cycle the requester
    // decides afresh whether to request again.
    task automatic agents_drive();
        if (cpu_req && acc_v && !acc_vid) begin
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = pick_cpu_addr();
            cpu_wdata = 16'($urandom);
        end else if (cpu_req && !(rsp_v && !rsp_vid)) begin
            cpu_req = 1'b1;
        end else begin
            cpu_req   = ($urandom_range(0, 99) < p_cpu);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = pick_cpu_addr();
            cpu_wdata = 16'($urandom);
        end
        if (vid_req && acc_v && acc_vid) begin
            vid_addr = pick_vid_addr();
        end else if (vid_req && !(rsp_v && rsp_vid)) begin
            vid_req = 1'b1;
        end else begin
            vid_req  = ($urandom_range(0, 99) < p_vid);
            vid_addr = pick_vid_addr();
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 15'h0; cpu_wdata = 16'h0;
        vid_req = 1'b0; vid_addr = 13'h0;
        w_cpu_req = 1'b0; w_cpu_we = 1'b0; w_cpu_addr = 15'h0; w_cpu_wdata = 16'h0;
        w_vid_req = 1'b0; w_vid_addr = 13'h0;
        repeat (3) cyc();
        reset_n = 1'b1;
        cyc(); cyc();

        // CPU write: command in cycle 1, ack in cycle 2, stalled in cycles 0-1.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0010; cpu_wdata = 16'h3039;
        #3 check_eq("wr_stall_c0", cpu_stall, 1);
        cyc();
        // Changing the inputs after the grant must not disturb the access.
        cpu_we = 1'b0; cpu_addr = 15'h7777; cpu_wdata = 16'h0000;
        #3 check_eq("wr_ram_we_c1", ram_we, 1);
        check_eq("wr_ram_addr_c1", ram_addr, 15'h0010);
        check_eq("wr_ram_wdata_c1", ram_wdata, 16'h3039);
        check_eq("wr_stall_c1", cpu_stall, 1);
        cyc();
        cpu_req = 1'b0;
        #3 check_eq("wr_ack_c2", cpu_ack, 1);
        cyc();

        // CPU read of a preloaded word.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h03EB;
        cyc(); cyc();
        cpu_req = 1'b0;
        #3 check_eq("rd_ack", cpu_ack, 1);
        check_eq("rd_data", cpu_rdata, 16'h1234);
        cyc();

        // Video reads: normal base, and the wrap instance.
        vid_req = 1'b1; vid_addr = 13'h0005;
        w_vid_req = 1'b1; w_vid_addr = 13'h0002;
        cyc();
        #3 check_eq("vid_ram_addr", ram_addr, 15'h4005);
        check_eq("vid_ram_we", ram_we, 0);
        check_eq("wrap_ram_addr", w_ram_addr, 15'h0001);
        check_eq("wrap_ram_en", w_ram_en, 1);
        cyc();
        vid_req = 1'b0; w_vid_req = 1'b0;
        #3 check_eq("vid_ack", vid_ack, 1);
        check_eq("vid_data", vid_rdata, 16'hBEEF);
        check_eq("wrap_ack", w_vid_ack, 1);
        check_eq("wrap_data", w_vid_rdata, 16'h1001);
        cyc();

        // Reset during the command cycle of a CPU write aborts it.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0020; cpu_wdata = 16'hAAAA;
        cyc();
        reset_n = 1'b0;
        #3 check_eq("abort_ram_en", ram_en, 0);
        check_eq("abort_ram_we", ram_we, 0);
        check_eq("abort_stall", cpu_stall, 1);
        cyc();
        #3 check_eq("abort_no_ack", cpu_ack, 0);
        cyc();
        reset_n = 1'b1;
        cyc();
        #3 check_eq("regrant_ram_en", ram_en, 1);
        check_eq("regrant_ram_we", ram_we, 1);
        check_eq("regrant_ram_addr", ram_addr, 15'h0020);
        cyc();
        cpu_req = 1'b0;
        #3 check_eq("regrant_ack", cpu_ack, 1);
        cyc();

        // Continuous contention from a fresh reset: four CPU grants, then one video grant.
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0003;
        vid_req = 1'b1; vid_addr = 13'h0007;
        rec_on  = 1'b1;
        repeat (45) cyc();
        cpu_req = 1'b0; vid_req = 1'b0;
        rec_on  = 1'b0;
        cyc(); cyc(); cyc();
        check_eq("order_count", ack_q.size() >= 20, 1);
        for (int k = 0; k < 20 && k < ack_q.size(); k++) begin
            check_eq($sformatf("order_%0d", k), ack_q[k], (k % 5 == 4) ? 1 : 0);
        end

        // Randomized traffic at several load levels.
        p_cpu = 50; p_vid = 40;
        repeat (1500) begin agents_drive(); cyc(); end
        p_cpu = 95; p_vid = 90;
        repeat (1000) begin agents_drive(); cyc(); end
        p_cpu = 20; p_vid = 70;
        repeat (800) begin agents_drive(); cyc(); end
        p_cpu = 0; p_vid = 0;
        repeat (10) begin agents_drive(); cyc(); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
